// File: rtl/ls_queue_if.sv
// Bundles the dispatch, CDB snoop/grant and AGU issue signals of the load/store queue.
// The queue connects through the slave modport; the dispatch/CDB/AGU side uses master.
interface ls_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;

  logic             disp_valid;
  logic             disp_ready;
  logic             disp_ls;
  logic [TAG_W-1:0] disp_rob_tag;
  logic             disp_base_rdy;
  logic [31:0]      disp_base;
  logic [31:0]      disp_imm;
  logic             disp_data_rdy;
  logic [31:0]      disp_data;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_req;
  logic             cdb_grant;

  logic             agu_issue;
  logic             agu_ls;
  logic [31:0]      agu_addr;
  logic [31:0]      agu_data;
  logic [TAG_W-1:0] agu_tag;
  logic             agu_tag_valid;

  logic [CNT_W-1:0] count;

  modport master (
    output flush, disp_valid, disp_ls, disp_rob_tag, disp_base_rdy, disp_base,
           disp_imm, disp_data_rdy, disp_data, cdb_valid, cdb_tag, cdb_data, cdb_grant,
    input  disp_ready, cdb_req, agu_issue, agu_ls, agu_addr, agu_data, agu_tag,
           agu_tag_valid, count
  );

  modport slave (
    input  flush, disp_valid, disp_ls, disp_rob_tag, disp_base_rdy, disp_base,
           disp_imm, disp_data_rdy, disp_data, cdb_valid, cdb_tag, cdb_data, cdb_grant,
    output disp_ready, cdb_req, agu_issue, agu_ls, agu_addr, agu_data, agu_tag,
           agu_tag_valid, count
  );
endinterface

// File: rtl/ls_queue.sv
// In-order load/store queue: circular buffer of entries that snoop the CDB for
// missing operands; the head issues to the AGU strictly in program order.

// One queue slot: captures a dispatched op (with same-cycle CDB bypass) and
// keeps snooping the CDB for whichever operands are still outstanding.
module ls_queue_entry #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             pop,
  input  logic             wr_ls,
  input  logic [TAG_W-1:0] wr_rob_tag,
  input  logic             wr_base_rdy,
  input  logic [31:0]      wr_base,
  input  logic [31:0]      wr_imm,
  input  logic             wr_data_rdy,
  input  logic [31:0]      wr_data,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             valid,
  output logic             ls,
  output logic [TAG_W-1:0] rob_tag,
  output logic             base_rdy,
  output logic [31:0]      base,
  output logic [31:0]      imm,
  output logic             data_rdy,
  output logic [31:0]      data
);
  logic base_byp, data_byp, base_hit, data_hit;

  assign base_byp = ~wr_base_rdy & cdb_valid & (wr_base[TAG_W-1:0] == cdb_tag);
  assign data_byp = wr_ls & ~wr_data_rdy & cdb_valid & (wr_data[TAG_W-1:0] == cdb_tag);
  assign base_hit = valid & ~base_rdy & cdb_valid & (base[TAG_W-1:0] == cdb_tag);
  assign data_hit = valid & ~data_rdy & cdb_valid & (data[TAG_W-1:0] == cdb_tag);

  // Push and pop never target the same slot: that needs full or empty.
  always_ff @(posedge clk) begin
    if (rst || clr)  valid <= 1'b0;
    else if (wr_en)  valid <= 1'b1;
    else if (pop)    valid <= 1'b0;
  end

  // Payload is qualified by valid, so it needs no reset. Loads never wait on data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ls       <= wr_ls;
      rob_tag  <= wr_rob_tag;
      imm      <= wr_imm;
      base_rdy <= wr_base_rdy | base_byp;
      base     <= base_byp ? cdb_data : wr_base;
      data_rdy <= ~wr_ls | wr_data_rdy | data_byp;
      data     <= data_byp ? cdb_data : wr_data;
    end else begin
      if (base_hit) begin
        base_rdy <= 1'b1;
        base     <= cdb_data;
      end
      if (data_hit) begin
        data_rdy <= 1'b1;
        data     <= cdb_data;
      end
    end
  end
endmodule

module ls_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  ls_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             valid;
    logic             ls;
    logic [TAG_W-1:0] rob_tag;
    logic             base_rdy;
    logic [31:0]      base;
    logic [31:0]      imm;
    logic             data_rdy;
    logic [31:0]      data;
  } ent_t;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop, head_rdy;
  ent_t             hd;

  logic [DEPTH-1:0]             e_valid, e_ls, e_base_rdy, e_data_rdy;
  logic [DEPTH-1:0][TAG_W-1:0]  e_rob_tag;
  logic [DEPTH-1:0][31:0]       e_base, e_imm, e_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    ls_queue_entry #(.TAG_W(TAG_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .clr         (bus.flush),
      .wr_en       (push & (tail == PTR_W'(i))),
      .pop         (pop & (head == PTR_W'(i))),
      .wr_ls       (bus.disp_ls),
      .wr_rob_tag  (bus.disp_rob_tag),
      .wr_base_rdy (bus.disp_base_rdy),
      .wr_base     (bus.disp_base),
      .wr_imm      (bus.disp_imm),
      .wr_data_rdy (bus.disp_data_rdy),
      .wr_data     (bus.disp_data),
      .cdb_valid   (bus.cdb_valid),
      .cdb_tag     (bus.cdb_tag),
      .cdb_data    (bus.cdb_data),
      .valid       (e_valid[i]),
      .ls          (e_ls[i]),
      .rob_tag     (e_rob_tag[i]),
      .base_rdy    (e_base_rdy[i]),
      .base        (e_base[i]),
      .imm         (e_imm[i]),
      .data_rdy    (e_data_rdy[i]),
      .data        (e_data[i])
    );
  end

  always_comb begin
    hd          = '0;
    hd.valid    = e_valid[head];
    hd.ls       = e_ls[head];
    hd.rob_tag  = e_rob_tag[head];
    hd.base_rdy = e_base_rdy[head];
    hd.base     = e_base[head];
    hd.imm      = e_imm[head];
    hd.data_rdy = e_data_rdy[head];
    hd.data     = e_data[head];
  end

  // Full blocks dispatch even when the head pops this cycle (no pop bypass).
  assign bus.disp_ready = (count < CNT_W'(DEPTH));
  assign push           = bus.disp_valid & bus.disp_ready & ~bus.flush;
  assign head_rdy       = hd.valid & hd.base_rdy & (~hd.ls | hd.data_rdy);
  assign pop            = head_rdy & (hd.ls | bus.cdb_grant) & ~bus.flush;

  assign bus.cdb_req       = head_rdy & ~hd.ls & ~bus.flush;
  assign bus.agu_issue     = pop;
  assign bus.agu_ls        = pop & hd.ls;
  assign bus.agu_tag_valid = pop & ~hd.ls;
  assign bus.agu_addr      = pop ? (hd.base + hd.imm) : 32'h0;
  assign bus.agu_data      = pop ? hd.data : 32'h0;
  assign bus.agu_tag       = pop ? hd.rob_tag : '0;
  assign bus.count         = count;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
